tdm_pwm_ctx: RTL and testbench
==============================

Name: tdm_pwm_ctx

Overview:
- Parametrised time-division-multiplexed PWM generator. One shared counter/compare engine is time-sliced across NUM_CH channels, and per-channel state lives in a context array.
- Successor to the fixed 16-channel TDM PWM. Adds:
  - non-power-of-two channel count
  - programmable period
  - shadowed (glitch-free) duty updates at period boundary
  - per-channel output polarity
  - valid/ready config port
- Sits between the register/config interface and the LED/actuator pads.

Parameters:
- NUM_CH, 16, number of PWM channels (2..256, need not be a power of two)
- CNT_W, 16, width of per-channel counter, duty and period
- IDX_W, $clog2(NUM_CH), derived channel-index width; not overridden

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  scheduler advance enable; when low, all state frozen
- period  in  CNT_W  global period; counter runs 0..period inclusive
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_idx  in  IDX_W  target channel
- cfg_duty  in  CNT_W  new duty (shadow)
- cfg_pol  in  1  output polarity for channel (1 = invert)
- pwm_out  out  NUM_CH  PWM outputs
- frame_tick  out  1  one-cycle pulse when scheduler wraps NUM_CH-1 -> 0

Behaviour:
- Reset: idx=0, all context fields 0, pwm_out=0, frame_tick=0. Reset mid-operation discards everything, including an in-flight config.
- Context per channel: cnt[CNT_W], duty_act[CNT_W], duty_shd[CNT_W], pol.
- Scheduler: when en=1, idx <= (idx==NUM_CH-1) ? 0 : idx+1.
  - frame_tick registered, high the cycle after a visit to NUM_CH-1.
- Visit of channel idx (en=1), all results registered on the same edge:
  - pwm_out[idx] <= pol ^ (cnt < duty_act); other bits hold.
  - cnt <= (cnt >= period) ? 0 : cnt+1. A period lowered below the current cnt forces a wrap on the next visit.
  - When cnt >= period (boundary), duty_act <= duty_shd.
- Latency: pwm_out[ch] changes 1 clk after its visit and holds for NUM_CH clks.
  - One PWM period = (period+1) visits = (period+1)*NUM_CH clks.
- Duty rules (pol=0):
  - duty=0: always low.
  - duty >= period+1: always high.
  - duty=period: low only at cnt==period.
- Config handshake:
  - cfg_ready = ~(en & (cfg_idx == idx)), combinational. This stalls the single context write port for one clk on collision.
  - On accept, duty_shd[cfg_idx] <= cfg_duty and pol[cfg_idx] <= cfg_pol.
  - pol takes effect at that channel's next visit. Duty takes effect at its next boundary.
  - cfg_idx >= NUM_CH: accepted and ignored (no write).
  - A second write before the boundary overwrites the shadow; last write wins.
- en=0: cfg still accepted (cfg_ready=1); outputs hold.

Optional Feature:
- Macro TDM_PWM_CENTER_EN.
- Defined:
  - Adds a per-channel dir bit to the context and a cfg_center input (1 bit, latched with cfg_duty).
  - Centre-aligned channels count 0 -> period up, then period -> 0 down. Period = 2*period visits.
  - Shadow load occurs only at cnt==0 while down.
  - Compare and polarity are identical to edge-aligned mode.
- Undefined: no dir bit, no cfg_center port; all channels edge-aligned.

Decomposition:
- Package tdm_pwm_pkg:
  - ctx_t packed struct (cnt, duty_act, duty_shd, pol, and dir under macro)
  - default NUM_CH/CNT_W localparams
- Sub-module tdm_pwm_engine: combinational. Inputs are ctx_t, period and index-valid; outputs are next ctx_t and the compare bit. Instantiated once.
- Top holds the scheduler, context array, handshake and output registers.

Test Plan:
All scenarios use NUM_CH=4, CNT_W=8 unless stated.
- Reset: assert rst mid-run -> pwm_out=0, frame_tick=0 immediately. After release, first frame_tick 4 clks after the first en cycle.
- period=9, ch1 duty=3, pol=0 -> pwm_out[1] high for exactly 12 clks of every 40; other channels stay 0.
- Shadow update: ch0 duty 2 -> 7 written mid-period -> old duty persists until cnt wraps; the next period is high for 7 visits with no runt pulse.
- Collision: en=1, cfg_valid with cfg_idx==idx -> cfg_ready=0 that clk; retry next clk -> accepted, value lands.
- Boundaries: duty=0 -> always low; duty=10 with period=9 -> always high; pol=1 on duty=0 -> always high. NUM_CH=5 -> idx wraps 4 -> 0 and frame_tick every 5 clks.
- TDM_PWM_CENTER_EN: period=4, duty=2, center=1 -> visit-count sequence 0,1,2,3,4,3,2,1,0, with output high when cnt<2; shadow loads only at the down-count zero.

Source files
------------

// File: rtl/tdm_pwm_pkg.sv
// Shared types for the time-sliced PWM: per-channel context record and default sizing.
// Optional centre-aligned counting is enabled by TDM_PWM_CENTER_EN.
package tdm_pwm_pkg;

  localparam int DEF_NUM_CH = 16;
  localparam int DEF_CNT_W  = 16;
  // Context fields are held at a fixed maximum width; bits above CNT_W stay zero and are pruned.
  localparam int CNT_W_MAX  = 32;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] cnt;
    logic [CNT_W_MAX-1:0] duty_act;
    logic [CNT_W_MAX-1:0] duty_shd;
    logic                 pol;
`ifdef TDM_PWM_CENTER_EN
    logic                 center;
    logic                 dir;
`endif
  } ctx_t;

endpackage

// File: rtl/tdm_pwm_ctx_if.sv
// Configuration write port of the TDM PWM (valid/ready handshake).
// Carries cfg_center only when TDM_PWM_CENTER_EN is defined.
interface tdm_pwm_ctx_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_idx;
  logic [CNT_W-1:0] cfg_duty;
  logic             cfg_pol;
`ifdef TDM_PWM_CENTER_EN
  logic             cfg_center;
`endif

  modport master (
`ifdef TDM_PWM_CENTER_EN
    output cfg_center,
`endif
    output cfg_valid, cfg_idx, cfg_duty, cfg_pol,
    input  cfg_ready
  );

  modport slave (
`ifdef TDM_PWM_CENTER_EN
    input  cfg_center,
`endif
    input  cfg_valid, cfg_idx, cfg_duty, cfg_pol,
    output cfg_ready
  );
endinterface

// File: rtl/tdm_pwm_engine.sv
// Shared counter/compare engine: given one channel's context, produces its next context
// and PWM compare bit. Centre-aligned counting under TDM_PWM_CENTER_EN.
module tdm_pwm_engine
  import tdm_pwm_pkg::*;
(
  input  ctx_t                 ctx_i,
  input  logic [CNT_W_MAX-1:0] period_i,
  input  logic                 idx_valid_i,
  output ctx_t                 ctx_o,
  output logic                 cmp_o
);

  logic boundary;

  always_comb begin
    ctx_o    = ctx_i;
    cmp_o    = 1'b0;
    boundary = 1'b0;
    if (idx_valid_i) begin
      // Compare always uses the duty active before this visit, so a shadow load never truncates.
      cmp_o    = ctx_i.pol ^ (ctx_i.cnt < ctx_i.duty_act);
      boundary = (ctx_i.cnt >= period_i);
      ctx_o.cnt = boundary ? '0 : ctx_i.cnt + 1'b1;
      if (boundary) begin
        ctx_o.duty_act = ctx_i.duty_shd;
      end
`ifdef TDM_PWM_CENTER_EN
      ctx_o.dir = 1'b0;
      if (ctx_i.center) begin
        ctx_o.duty_act = ctx_i.duty_act;
        if (!ctx_i.dir) begin
          if (boundary) begin
            ctx_o.dir = 1'b1;
            ctx_o.cnt = (period_i == '0) ? '0 : period_i - 1'b1;
          end
        end else if (ctx_i.cnt == '0) begin
          ctx_o.cnt      = (period_i == '0) ? '0 : CNT_W_MAX'(1);
          ctx_o.duty_act = ctx_i.duty_shd;
        end else begin
          ctx_o.dir = 1'b1;
          ctx_o.cnt = ctx_i.cnt - 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/tdm_pwm_ctx.sv
// Time-division-multiplexed PWM: scheduler, per-channel context array, config port, outputs.
// Define TDM_PWM_CENTER_EN to add centre-aligned channels (cfg_center on the config port).
module tdm_pwm_ctx
  import tdm_pwm_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  period,
  tdm_pwm_ctx_if.slave      cfg,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_tick
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W + 1)'(NUM_CH);

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [NUM_CH-1:0]    pwm_q, pwm_d;
  ctx_t                 ctx_q [NUM_CH];
  ctx_t                 ctx_d [NUM_CH];

  ctx_t                 eng_cur;
  ctx_t                 eng_next;
  logic                 eng_cmp;
  logic                 idx_valid;
  logic                 cfg_wr;
  logic [CNT_W_MAX-1:0] period_ext;

  assign period_ext = CNT_W_MAX'(period);
  assign idx_valid  = ({1'b0, idx_q} < NUM_CH_W);

  // The context array has a single write port; a config write to the channel being visited waits.
  assign cfg.cfg_ready = ~(en & (cfg.cfg_idx == idx_q));
  assign cfg_wr        = cfg.cfg_valid & cfg.cfg_ready & ({1'b0, cfg.cfg_idx} < NUM_CH_W);

  assign eng_cur = idx_valid ? ctx_q[idx_q] : '0;

  tdm_pwm_engine u_engine (
    .ctx_i       (eng_cur),
    .period_i    (period_ext),
    .idx_valid_i (idx_valid),
    .ctx_o       (eng_next),
    .cmp_o       (eng_cmp)
  );

  always_comb begin
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (en) begin
      idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      frame_tick_d = (idx_q == LAST_IDX);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic visit;
    logic cfg_hit;
    ctx_t cfg_ctx;

    assign visit   = en & (idx_q == IDX_W'(gi));
    assign cfg_hit = cfg_wr & (cfg.cfg_idx == IDX_W'(gi));

    always_comb begin
      cfg_ctx          = ctx_q[gi];
      cfg_ctx.duty_shd = CNT_W_MAX'(cfg.cfg_duty);
      cfg_ctx.pol      = cfg.cfg_pol;
`ifdef TDM_PWM_CENTER_EN
      cfg_ctx.center   = cfg.cfg_center;
`endif
    end

    assign ctx_d[gi] = visit ? eng_next : (cfg_hit ? cfg_ctx : ctx_q[gi]);
    assign pwm_d[gi] = visit ? eng_cmp : pwm_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
      pwm_q        <= '0;
      ctx_q        <= '{default: '0};
    end else begin
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
      pwm_q        <= pwm_d;
      ctx_q        <= ctx_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tdm_pwm_ctx.sv
// Self-checking bench for tdm_pwm_ctx: directed scenarios plus randomized traffic against a
// per-channel behavioural model (NUM_CH=4) and a 5-channel scheduler check.
module tb_tdm_pwm_ctx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [7:0] period_a, period_b;
  logic [3:0] pwm_a;
  logic [4:0] pwm_b;
  logic       ft_a, ft_b;

  tdm_pwm_ctx_if #(.IDX_W(2), .CNT_W(8)) cif_a ();
  tdm_pwm_ctx_if #(.IDX_W(3), .CNT_W(8)) cif_b ();

  tdm_pwm_ctx #(.NUM_CH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .period(period_a), .cfg(cif_a),
    .pwm_out(pwm_a), .frame_tick(ft_a));

  tdm_pwm_ctx #(.NUM_CH(5), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .period(period_b), .cfg(cif_b),
    .pwm_out(pwm_b), .frame_tick(ft_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: position within the period, active/shadow duty, polarity per channel.
  int         m_cnt [4];
  int         m_act [4];
  int         m_shd [4];
  bit         m_pol [4];
  logic [3:0] m_out;
  logic       m_ft;
  int         m_idx;
  logic [3:0] m_skip;
  int         v_ch, v_cnt;
  bit         last_acc;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_act[i] = 0; m_shd[i] = 0; m_pol[i] = 0;
    end
    m_out = '0; m_ft = 0; m_idx = 0; v_ch = -1; v_cnt = 0;
  endtask

  // One clock of DUT A: check ready, advance model across the edge, check outputs.
  task automatic step();
    bit exp_ready;
    int ci;
    #1;
    exp_ready = !(en_a && (cif_a.cfg_idx == 2'(m_idx)));
    checks++;
    if (cif_a.cfg_ready !== exp_ready) begin
      failures++;
      $display("FAIL cfg_ready t=%0t got=%b exp=%b", $time, cif_a.cfg_ready, exp_ready);
    end
    last_acc = cif_a.cfg_valid && exp_ready;
    if (en_a) begin
      v_ch  = m_idx;
      v_cnt = m_cnt[m_idx];
      m_out[m_idx] = m_pol[m_idx] ^ (m_cnt[m_idx] < m_act[m_idx]);
      if (m_cnt[m_idx] >= int'(period_a)) begin
        m_cnt[m_idx] = 0;
        m_act[m_idx] = m_shd[m_idx];
      end else begin
        m_cnt[m_idx] = m_cnt[m_idx] + 1;
      end
      m_ft  = (m_idx == 3);
      m_idx = (m_idx + 1) % 4;
    end else begin
      v_ch = -1;
      m_ft = 0;
    end
    if (last_acc) begin
      ci = int'(cif_a.cfg_idx);
      m_shd[ci] = int'(cif_a.cfg_duty);
      m_pol[ci] = cif_a.cfg_pol;
    end
    @(negedge clk);
    checks++;
    if ((pwm_a & ~m_skip) !== (m_out & ~m_skip)) begin
      failures++;
      $display("FAIL pwm_out t=%0t got=%b exp=%b", $time, pwm_a, m_out);
    end
    checks++;
    if (ft_a !== m_ft) begin
      failures++;
      $display("FAIL frame_tick t=%0t got=%b exp=%b", $time, ft_a, m_ft);
    end
  endtask

  task automatic cfg_write(input int idx, input int duty, input bit pol, input bit center);
    cif_a.cfg_valid = 1'b1;
    cif_a.cfg_idx   = 2'(idx);
    cif_a.cfg_duty  = 8'(duty);
    cif_a.cfg_pol   = pol;
`ifdef TDM_PWM_CENTER_EN
    cif_a.cfg_center = center;
`endif
    last_acc = 0;
    for (int t = 0; t < 4 && !last_acc; t++) step();
    if (!last_acc) begin
      checks++; failures++;
      $display("FAIL cfg_write_timeout ch=%0d got=not_accepted exp=accepted", idx);
    end
    cif_a.cfg_valid = 1'b0;
`ifdef TDM_PWM_CENTER_EN
    cif_a.cfg_center = 1'b0;
`endif
    if (center) m_skip = m_skip;
  endtask

  task automatic test_reset();
    en_a = 0; period_a = 8'd3;
    for (int i = 0; i < 4; i++) cfg_write(i, 0, 1'b1, 1'b0);
    en_a = 1;
    repeat (8) step();
    checks++;
    if (pwm_a !== 4'hF) begin
      failures++; $display("FAIL pre_reset_pwm got=%b exp=1111", pwm_a);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (pwm_a !== 4'h0 || ft_a !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b/%b exp=0000/0", pwm_a, ft_a);
    end
    model_reset();
    @(negedge clk);
    rst = 0; en_a = 0;
    step();
    en_a = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (ft_a !== (k == 4)) begin
        failures++; $display("FAIL first_frame_tick clk=%0d got=%b exp=%b", k, ft_a, (k == 4));
      end
    end
  endtask

  task automatic test_duty_period();
    int high1, other;
    en_a = 0; period_a = 8'd9;
    cfg_write(1, 3, 1'b0, 1'b0);
    en_a = 1;
    repeat (80) step();
    high1 = 0; other = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      high1 += int'(pwm_a[1]);
      other += int'(pwm_a[0]) + int'(pwm_a[2]) + int'(pwm_a[3]);
    end
    checks++;
    if (high1 !== 12) begin
      failures++; $display("FAIL duty3_high_clks got=%0d exp=12", high1);
    end
    checks++;
    if (other !== 0) begin
      failures++; $display("FAIL other_channels_high got=%0d exp=0", other);
    end
  endtask

  task automatic test_shadow();
    int highs, visits, t;
    bit found;
    period_a = 8'd9;
    cfg_write(0, 2, 1'b0, 1'b0);
    repeat (80) step();
    found = 0;
    for (t = 0; t < 200 && !found; t++) begin
      step();
      found = (v_ch == 0 && v_cnt == 4);
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL shadow_sync got=timeout exp=visit_cnt4");
    end
    cfg_write(0, 7, 1'b0, 1'b0);
    highs = 0; found = 0;
    for (t = 0; t < 100 && !found; t++) begin
      step();
      if (v_ch == 0) begin
        highs += int'(pwm_a[0]);
        found = (v_cnt == 9);
      end
    end
    checks++;
    if (highs !== 0 || !found) begin
      failures++; $display("FAIL shadow_old_tail got=%0d exp=0", highs);
    end
    highs = 0; visits = 0;
    for (t = 0; t < 100 && visits < 10; t++) begin
      step();
      if (v_ch == 0) begin
        highs += int'(pwm_a[0]);
        visits++;
      end
    end
    checks++;
    if (highs !== 7 || visits !== 10) begin
      failures++; $display("FAIL shadow_new_period got=%0d exp=7", highs);
    end
  endtask

  task automatic test_collision();
    int t;
    en_a = 1; period_a = 8'd9;
    for (t = 0; t < 8 && m_idx != 2; t++) step();
    cif_a.cfg_valid = 1'b1; cif_a.cfg_idx = 2'd2; cif_a.cfg_duty = 8'd0; cif_a.cfg_pol = 1'b1;
    #1;
    checks++;
    if (cif_a.cfg_ready !== 1'b0) begin
      failures++; $display("FAIL collision_stall got=%b exp=0", cif_a.cfg_ready);
    end
    step();
    #1;
    checks++;
    if (cif_a.cfg_ready !== 1'b1) begin
      failures++; $display("FAIL collision_retry got=%b exp=1", cif_a.cfg_ready);
    end
    step();
    cif_a.cfg_valid = 1'b0;
    for (t = 0; t < 8 && v_ch != 2; t++) step();
    checks++;
    if (pwm_a[2] !== 1'b1) begin
      failures++; $display("FAIL collision_value_lands got=%b exp=1", pwm_a[2]);
    end
  endtask

  task automatic test_boundaries();
    int h [4];
    period_a = 8'd9;
    cfg_write(0, 0, 1'b0, 1'b0);
    cfg_write(1, 10, 1'b0, 1'b0);
    cfg_write(2, 0, 1'b1, 1'b0);
    cfg_write(3, 9, 1'b0, 1'b0);
    repeat (80) step();
    for (int i = 0; i < 4; i++) h[i] = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      for (int i = 0; i < 4; i++) h[i] += int'(pwm_a[i]);
    end
    checks++;
    if (h[0] !== 0)  begin failures++; $display("FAIL duty0_low got=%0d exp=0", h[0]); end
    checks++;
    if (h[1] !== 40) begin failures++; $display("FAIL duty_over_period_high got=%0d exp=40", h[1]); end
    checks++;
    if (h[2] !== 40) begin failures++; $display("FAIL pol1_duty0_high got=%0d exp=40", h[2]); end
    checks++;
    if (h[3] !== 36) begin failures++; $display("FAIL duty_eq_period got=%0d exp=36", h[3]); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      en_a            = ($urandom_range(3) != 0);
      cif_a.cfg_valid = $urandom_range(1);
      cif_a.cfg_idx   = 2'($urandom_range(3));
      cif_a.cfg_duty  = 8'($urandom_range(14));
      cif_a.cfg_pol   = $urandom_range(1);
      if ($urandom_range(9) == 0) period_a = 8'($urandom_range(12));
      step();
    end
    cif_a.cfg_valid = 1'b0;
    en_a = 0;
  endtask

  task automatic test_ch5();
    int b_idx, nft;
    bit exp_ft;
    b_idx = 0; nft = 0;
    period_b = 8'd0; en_b = 1;
    cif_b.cfg_valid = 1'b0; cif_b.cfg_idx = 3'd4;
    for (int t = 0; t < 25; t++) begin
      #1;
      checks++;
      if (cif_b.cfg_ready !== (b_idx != 4)) begin
        failures++; $display("FAIL ch5_idx_probe cyc=%0d got=%b exp=%b", t, cif_b.cfg_ready, (b_idx != 4));
      end
      exp_ft = (b_idx == 4);
      b_idx  = (b_idx + 1) % 5;
      @(negedge clk);
      checks++;
      if (ft_b !== exp_ft) begin
        failures++; $display("FAIL ch5_frame_tick cyc=%0d got=%b exp=%b", t, ft_b, exp_ft);
      end
      nft += int'(ft_b);
    end
    checks++;
    if (nft !== 5) begin failures++; $display("FAIL ch5_tick_count got=%0d exp=5", nft); end
    cif_b.cfg_valid = 1'b1; cif_b.cfg_idx = 3'd6; cif_b.cfg_duty = 8'hFF; cif_b.cfg_pol = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      checks++;
      if (cif_b.cfg_ready !== 1'b1) begin
        failures++; $display("FAIL ch5_oob_ready got=%b exp=1", cif_b.cfg_ready);
      end
      @(negedge clk);
      checks++;
      if (pwm_b !== 5'b0) begin
        failures++; $display("FAIL ch5_oob_ignored got=%b exp=00000", pwm_b);
      end
    end
    cif_b.cfg_valid = 1'b0;
    en_b = 0;
  endtask

`ifdef TDM_PWM_CENTER_EN
  task automatic test_center();
    bit s [16];
    int n, highs, diff;
    m_skip = 4'b1000;
    en_a = 1; period_a = 8'd4;
    cfg_write(3, 2, 1'b0, 1'b1);
    repeat (120) step();
    n = 0;
    for (int t = 0; t < 100 && n < 16; t++) begin
      step();
      if (v_ch == 3) begin s[n] = pwm_a[3]; n++; end
    end
    highs = 0; diff = 0;
    for (int i = 0; i < 16; i++) highs += int'(s[i]);
    for (int i = 0; i < 8; i++) diff += int'(s[i] != s[i + 8]);
    checks++;
    if (highs !== 6 || n !== 16) begin
      failures++; $display("FAIL center_high_visits got=%0d exp=6", highs);
    end
    checks++;
    if (diff !== 0) begin
      failures++; $display("FAIL center_period8 got=%0d exp=0", diff);
    end
  endtask
`endif

  initial begin
    rst = 1; en_a = 0; en_b = 0; period_a = '0; period_b = '0;
    cif_a.cfg_valid = 0; cif_a.cfg_idx = '0; cif_a.cfg_duty = '0; cif_a.cfg_pol = 0;
    cif_b.cfg_valid = 0; cif_b.cfg_idx = '0; cif_b.cfg_duty = '0; cif_b.cfg_pol = 0;
`ifdef TDM_PWM_CENTER_EN
    cif_a.cfg_center = 0; cif_b.cfg_center = 0;
`endif
    m_skip = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_duty_period();
    test_shadow();
    test_collision();
    test_boundaries();
    test_random();
    test_ch5();
`ifdef TDM_PWM_CENTER_EN
    test_center();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
